// File: rtl/abc_def_seq_arb_pkg.sv
// Shared types and widths for the abc/def sequencing arbiter.
package abc_def_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ABC_ISSUE = 3'd1,
    S_ABC_WAIT  = 3'd2,
    S_DEF_ISSUE = 3'd3,
    S_DEF_WAIT  = 3'd4,
    S_RESP      = 3'd5
  } state_e;

  localparam int B_W         = 3;
  localparam int E3_W        = 4;
  localparam int A_W         = 2;
  localparam int D_W         = 2;
  localparam int TIMEOUT_DEF = 15;

  // Wait counter width: at least 4 bits, wider only if the timeout needs it.
  function automatic int cnt_w(input int t);
    return (t >= 16) ? $clog2(t + 1) : 4;
  endfunction

endpackage

// File: rtl/abc_def_seq_arb_if.sv
// Bus bundle between requesters, the sequencer and the abc/def pair.
// master = the sequencer, slave = the surrounding environment.
interface abc_def_seq_arb_if #(parameter int NREQ = 2);
  import abc_def_seq_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [B_W*NREQ-1:0]  req_b;
  logic [E3_W*NREQ-1:0] req_e3;
  logic [NREQ-1:0]      rsp_valid;
  logic                 rsp_f;
  logic                 rsp_err;
  logic                 abc_start;
  logic [A_W-1:0]       signal_a;
  logic [B_W-1:0]       signal_b;
  logic                 abc_done;
  logic                 signal_c;
  logic                 def_start;
  logic [D_W-1:0]       signal_d;
  logic [E3_W-1:0]      signal_e3;
  logic                 def_done;
  logic                 signal_f;

  modport master (
    input  req_valid, req_b, req_e3, abc_done, signal_c, def_done, signal_f,
    output req_ready, rsp_valid, rsp_f, rsp_err, abc_start, signal_a, signal_b,
           def_start, signal_d, signal_e3
  );

  modport slave (
    output req_valid, req_b, req_e3, abc_done, signal_c, def_done, signal_f,
    input  req_ready, rsp_valid, rsp_f, rsp_err, abc_start, signal_a, signal_b,
           def_start, signal_d, signal_e3
  );

endinterface

// File: rtl/abc_def_seq_arb_rr_arb.sv
// Round-robin grant: one-hot grant of the first request at/after the
// pointer; pointer moves past the granted requester when i_adv is high.
module abc_def_seq_arb_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_adv,
  output logic [NREQ-1:0] o_gnt
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_idx;
  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_back;
  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_rot_gnt;

  // Rotate so the pointer position is bit 0, isolate the lowest set bit,
  // then rotate the one-hot back into requester order.
  assign w_dbl     = {i_req, i_req} >> r_ptr;
  assign w_rot     = w_dbl[NREQ-1:0];
  assign w_rot_gnt = w_rot & (~w_rot + NREQ'(1));
  assign w_back    = {w_rot_gnt, w_rot_gnt} << r_ptr;
  assign o_gnt     = w_back[2*NREQ-1:NREQ];

  // Encode the granted index for the pointer update.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (o_gnt[i]) w_idx = PW'(i);
    end
  end

  // Pointer advances to the requester after the one just granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/abc_def_seq_arb.sv
// Round-robin sequencer sharing one abc->def chain between NREQ requesters.
// One job in flight: grant, start abc, capture c, start def, capture f,
// return f to the owner.
// Optional: ABC_DEF_SEQ_TIMEOUT_EN adds a per-WAIT timeout that ends the
// job with rsp_err=1 and rsp_f=0.
module abc_def_seq_arb
  import abc_def_seq_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               reset,
  abc_def_seq_arb_if.master bus
);

  state_e            r_state, w_next;
  logic [NREQ-1:0]   r_owner;
  logic [B_W-1:0]    r_b;
  logic [E3_W-1:0]   r_e3;
  logic              r_c;
  logic              r_f;
  logic              r_f_last;
  logic [NREQ-1:0]   w_gnt;
  logic              w_adv;
  logic              w_done;
  logic              w_expire;
  logic              w_err;
  logic [B_W-1:0]    w_b_sel;
  logic [E3_W-1:0]   w_e3_sel;

  abc_def_seq_arb_rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .clk   (clk),
    .reset (reset),
    .i_req (bus.req_valid),
    .i_adv (w_adv),
    .o_gnt (w_gnt)
  );

  assign w_adv  = (r_state == S_IDLE) && (|w_gnt);
  assign w_done = ((r_state == S_ABC_WAIT) && bus.abc_done) ||
                  ((r_state == S_DEF_WAIT) && bus.def_done);

`ifdef ABC_DEF_SEQ_TIMEOUT_EN
  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_err    = r_err;

  // Wait counter restarts in each ISSUE state; expiry without done flags an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ABC_ISSUE || r_state == S_DEF_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_ABC_WAIT || r_state == S_DEF_WAIT)
        r_cnt <= r_cnt + 1'b1;
      if (w_adv)
        r_err <= 1'b0;
      else if ((r_state == S_ABC_WAIT || r_state == S_DEF_WAIT) && w_expire && !w_done)
        r_err <= 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
  assign w_err    = 1'b0;
`endif

  // Select the granted requester's operands.
  always_comb begin
    w_b_sel  = '0;
    w_e3_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_b_sel  = w_b_sel  | (bus.req_b[B_W*i +: B_W]   & {B_W{w_gnt[i]}});
      w_e3_sel = w_e3_sel | (bus.req_e3[E3_W*i +: E3_W] & {E3_W{w_gnt[i]}});
    end
  end

  // Job sequence; a done arriving with expiry counts as normal completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_adv) w_next = S_ABC_ISSUE;
      S_ABC_ISSUE: w_next = S_ABC_WAIT;
      S_ABC_WAIT:  if (bus.abc_done) w_next = S_DEF_ISSUE;
                   else if (w_expire) w_next = S_RESP;
      S_DEF_ISSUE: w_next = S_DEF_WAIT;
      S_DEF_WAIT:  if (bus.def_done || w_expire) w_next = S_RESP;
      S_RESP:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Job context: owner/operands at grant, c and f at their done strobes,
  // f_last only from jobs that completed without error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner  <= '0;
      r_b      <= '0;
      r_e3     <= '0;
      r_c      <= 1'b0;
      r_f      <= 1'b0;
      r_f_last <= 1'b0;
    end else begin
      if (w_adv) begin
        r_owner <= w_gnt;
        r_b     <= w_b_sel;
        r_e3    <= w_e3_sel;
        r_f     <= 1'b0;
      end
      if (r_state == S_ABC_WAIT && bus.abc_done) r_c <= bus.signal_c;
      if (r_state == S_DEF_WAIT && bus.def_done) r_f <= bus.signal_f;
      if (r_state == S_RESP && !w_err)           r_f_last <= r_f;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE) ? w_gnt : '0;
  assign bus.abc_start = (r_state == S_ABC_ISSUE);
  assign bus.def_start = (r_state == S_DEF_ISSUE);
  assign bus.signal_a  = {1'b0, r_f_last};
  assign bus.signal_b  = r_b;
  assign bus.signal_e3 = r_e3;
  assign bus.signal_d  = (r_state == S_DEF_ISSUE || r_state == S_DEF_WAIT) ? {1'b1, r_c} : '0;
  assign bus.rsp_valid = (r_state == S_RESP) ? r_owner : '0;
  assign bus.rsp_f     = (r_state == S_RESP) && r_f;
  assign bus.rsp_err   = (r_state == S_RESP) && w_err;

endmodule

// File: tb/tb_abc_def_seq_arb.sv
// Bench for abc_def_seq_arb: directed steps plus randomized jobs checked
// against a job-level model (rotation pointer, last f, expected timing).
module tb_abc_def_seq_arb;
  localparam int NREQ = 2;
  localparam int TO   = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  abc_def_seq_arb_if #(.NREQ(NREQ)) bus ();

  abc_def_seq_arb #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_run  = 0;
  int   n_fail = 0;
  int   m_ptr;
  logic m_flast;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int pred_owner(input logic [NREQ-1:0] v);
    int j;
    for (int i = 0; i < NREQ; i++) begin
      j = (m_ptr + i) % NREQ;
      if (((v >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  // mode: 0 normal, 1 abc_done pulse during ABC_ISSUE, 2 reset in DEF_WAIT,
  // 3 def_done withheld (timeout or indefinite wait depending on build)
  task automatic run_job(input logic [NREQ-1:0] vld, input int adly, input int ddly,
                         input logic c, input logic f, input int mode, output int owner);
    logic [2:0] eb;
    logic [3:0] ee;
    step();
    bus.req_valid = vld;
    #1;
    owner = pred_owner(vld);
    chk("grant", bus.req_ready, 32'(1) << owner);
    eb = 3'(bus.req_b >> (3 * owner));
    ee = 4'(bus.req_e3 >> (4 * owner));
    m_ptr = (owner + 1) % NREQ;
    // ABC_ISSUE
    step();
    bus.req_b    = 6'($urandom);
    bus.req_e3   = 8'($urandom);
    bus.abc_done = (mode == 1);
    bus.signal_c = ~c;
    #1;
    chk("abc_start", bus.abc_start, 1);
    chk("ready_busy", bus.req_ready, 0);
    chk("signal_b", bus.signal_b, eb);
    chk("signal_e3", bus.signal_e3, ee);
    chk("signal_a", bus.signal_a, {1'b0, m_flast});
    chk("def_start_early", bus.def_start, 0);
    // ABC_WAIT
    for (int k = 0; k <= adly; k++) begin
      step();
      bus.abc_done = (k == adly);
      bus.signal_c = (k == adly) ? c : ~c;
      #1;
      chk("abc_wait_start", {bus.abc_start, bus.def_start}, 0);
      chk("abc_wait_b", bus.signal_b, eb);
      chk("abc_wait_a", bus.signal_a, {1'b0, m_flast});
      chk("abc_wait_rsp", bus.rsp_valid, 0);
    end
    // DEF_ISSUE
    step();
    bus.abc_done = 1'b0;
    #1;
    chk("def_start", bus.def_start, 1);
    chk("signal_d", bus.signal_d, {1'b1, c});
    chk("def_issue_e3", bus.signal_e3, ee);
    if (mode == 2) begin
      step();
      reset = 1'b1;
      bus.req_valid = '0;
      #1;
      chk("pre_reset_d", bus.signal_d, {1'b1, c});
      step();
      reset = 1'b0;
      #1;
      m_ptr = 0;
      m_flast = 1'b0;
      chk("rst_rsp", bus.rsp_valid, 0);
      chk("rst_outs", {bus.abc_start, bus.def_start, bus.signal_a, bus.signal_b, bus.signal_d}, 0);
      return;
    end
    if (mode == 3) begin
`ifdef ABC_DEF_SEQ_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
        step();
        #1;
        chk("to_wait_rsp", bus.rsp_valid, 0);
      end
      step();
      #1;
      chk("to_rsp_valid", bus.rsp_valid, 32'(1) << owner);
      chk("to_rsp_err", bus.rsp_err, 1);
      chk("to_rsp_f", bus.rsp_f, 0);
      return;
`else
      for (int k = 0; k < 40; k++) begin
        step();
        #1;
        chk("blk_rsp", bus.rsp_valid, 0);
        chk("blk_d", bus.signal_d, {1'b1, c});
      end
`endif
    end
    // DEF_WAIT
    for (int k = 0; k <= ddly; k++) begin
      step();
      bus.def_done = (k == ddly);
      bus.signal_f = (k == ddly) ? f : ~f;
      #1;
      chk("def_wait_rsp", bus.rsp_valid, 0);
      chk("def_wait_d", bus.signal_d, {1'b1, c});
      chk("def_wait_e3", bus.signal_e3, ee);
    end
    // RESP
    step();
    bus.def_done = 1'b0;
    #1;
    chk("rsp_valid", bus.rsp_valid, 32'(1) << owner);
    chk("rsp_f", bus.rsp_f, f);
    chk("rsp_err", bus.rsp_err, 0);
    m_flast = f;
  endtask

  initial begin
    int own;
    int r;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_b     = '0;
    bus.req_e3    = '0;
    bus.abc_done  = 1'b0;
    bus.signal_c  = 1'b0;
    bus.def_done  = 1'b0;
    bus.signal_f  = 1'b0;
    m_ptr   = 0;
    m_flast = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Idle after reset: everything quiet
    for (int k = 0; k < 10; k++) begin
      step();
      #1;
      chk("idle_abc_start", bus.abc_start, 0);
      chk("idle_outs", {bus.req_ready, bus.rsp_valid, bus.rsp_f, bus.rsp_err, bus.def_start,
                        bus.signal_a, bus.signal_b, bus.signal_d, bus.signal_e3}, 0);
    end

    // Single job from requester 0, minimum latency
    bus.req_b  = 6'b000_101;
    bus.req_e3 = 8'h0A;
    run_job(2'b01, 0, 0, 1'b1, 1'b1, 0, own);
    chk("t2_owner", own, 0);

    // Both valid: strict alternation (pointer now past requester 0)
    for (int k = 0; k < 4; k++) begin
      run_job(2'b11, $urandom_range(0, 2), $urandom_range(0, 2),
              1'($urandom), 1'($urandom), 0, own);
      chk("t3_rotate", own, (k + 1) % 2);
    end

    // abc_done during ABC_ISSUE must be ignored
    run_job(2'b11, 2, 1, 1'b0, 1'b1, 1, own);

    // Randomized jobs with idle gaps
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        step();
        bus.req_valid = '0;
        #1;
        chk("gap_ready", bus.req_ready, 0);
        chk("gap_abc_start", bus.abc_start, 0);
      end else begin
        run_job(NREQ'(r), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 0, own);
      end
    end

    // Reset in DEF_WAIT drops the job and clears the pointer
    run_job(2'b01, 0, 0, 1'b1, 1'b1, 0, own);
    run_job(2'b01, 1, 0, 1'b0, 1'b1, 2, own);
    run_job(2'b11, 0, 0, 1'b1, 1'b0, 0, own);
    chk("t5_ptr_reset", own, 0);

    // def_done withheld
    run_job(2'b11, 0, 0, 1'b1, 1'b1, 0, own);
    run_job(2'b10, 0, 0, 1'b0, 1'b0, 3, own);
    run_job(2'b11, 0, 1, 1'b1, 1'b0, 0, own);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
